// File: rtl/seq_tx.sv
// -----------------------------------------------------------------------------
// seq_tx
//
// Transmit side of the sequence capture path. Buffers up to DEPTH words of
// WIDTH bits and, on a start request, replays them in order as OUT_WIDTH-bit
// halves (high half first) over a valid/ack handshake. Playback does not
// consume the buffer, so a stored sequence can be replayed repeatedly.
//
// Ports:
//   clk      in   system clock, all logic on posedge
//   reset    in   asynchronous active-low reset
//   clr      in   synchronous clear of count, err and any playback in flight
//   wr_en    in   one-cycle write strobe (append wr_data while idle)
//   wr_data  in   word to append
//   start    in   one-cycle playback request
//   ack      in   consumer accepts the current dataOut (only while r_o=1)
//   dataOut  out  current half-word, zero when not presenting data
//   r_o      out  dataOut valid
//   busy     out  playback in progress
//   done     out  one-cycle pulse after the last half is accepted
//   count    out  number of stored words (0..DEPTH)
//   err      out  sticky error: 01 overflow, 10 empty start, 11 write while busy
// -----------------------------------------------------------------------------
module seq_tx #(
    parameter int DEPTH     = 10,
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 start,
    input  logic                 ack,
    output logic [OUT_WIDTH-1:0] dataOut,
    output logic                 r_o,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           count,
    output logic [1:0]           err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    state_t         state_q, state_d;
    logic [3:0]     count_q, count_d;
    logic [3:0]     rd_ptr_q, rd_ptr_d;
    logic [1:0]     err_q, err_d;
    logic [3:0]     count_inc;
    logic           mem_we;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Next-state, error and write-enable logic
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        err_d     = err_q;
        count_inc = count_q;
        mem_we    = 1'b0;

        if (clr) begin
            state_d  = IDLE;
            count_d  = 4'd0;
            rd_ptr_d = 4'd0;
            err_d    = 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        if (count_q < DEPTH_L) begin
                            mem_we    = 1'b1;
                            count_inc = count_q + 4'd1;
                        end else begin
                            err_d = 2'b01;
                        end
                    end
                    count_d = count_inc;
                    // A write in the same cycle as start is part of the replay,
                    // so the emptiness test uses the post-write count.
                    if (start) begin
                        if (count_inc == 4'd0) begin
                            err_d = 2'b10;
                        end else begin
                            rd_ptr_d = 4'd0;
                            state_d  = SEND_HI;
                        end
                    end
                end
                SEND_HI: begin
                    if (wr_en) err_d = 2'b11;
                    if (ack)   state_d = SEND_LO;
                end
                SEND_LO: begin
                    if (wr_en) err_d = 2'b11;
                    if (ack) begin
                        if (rd_ptr_q == count_q - 4'd1) begin
                            state_d = DONE;
                        end else begin
                            rd_ptr_d = rd_ptr_q + 4'd1;
                            state_d  = SEND_HI;
                        end
                    end
                end
                DONE: begin
                    // Buffer is still locked for the wrap-up cycle.
                    if (wr_en) err_d = 2'b11;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= 4'd0;
            rd_ptr_q <= 4'd0;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Storage is not reset; only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[count_q] <= wr_data;
    end

    // Outputs decoded from state and registers only (no path from ack).
    always_comb begin
        dataOut = '0;
        case (state_q)
            SEND_HI: dataOut = mem_q[rd_ptr_q][WIDTH-1:OUT_WIDTH];
            SEND_LO: dataOut = mem_q[rd_ptr_q][OUT_WIDTH-1:0];
            default: dataOut = '0;
        endcase
    end

    assign r_o   = (state_q == SEND_HI) || (state_q == SEND_LO);
    assign busy  = r_o;
    assign done  = (state_q == DONE);
    assign count = count_q;
    assign err   = err_q;

endmodule

// File: tb/tb_seq_tx.sv
module tb_seq_tx;

    localparam int DEPTH = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        start;
    logic        ack;
    logic [15:0] dataOut;
    logic        r_o;
    logic        busy;
    logic        done;
    logic [3:0]  count;
    logic [1:0]  err;

    int passed = 0;
    int total  = 0;

    // Reference model: the stored sequence and the expected error code.
    logic [31:0] model_q[$];
    logic [1:0]  model_err;

    seq_tx #(.DEPTH(DEPTH), .WIDTH(32), .OUT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .start(start), .ack(ack), .dataOut(dataOut), .r_o(r_o), .busy(busy),
        .done(done), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_q.delete();
        model_err = 2'b00;
    endtask

    task automatic write_word(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(w);
        else model_err = 2'b01;
        check("wr_count", 32'(count), 32'(model_q.size()));
        check("wr_err", 32'(err), 32'(model_err));
    endtask

    function automatic logic [15:0] exp_half(input int idx);
        logic [31:0] w;
        w = model_q[idx / 2];
        return (idx % 2 == 0) ? w[31:16] : w[15:0];
    endfunction

    // Consume the whole replay; playback has just been entered.
    task automatic drain(input bit random_ack, input bit inject_wr);
        int idx;
        int cyc;
        int n2;
        n2  = 2 * model_q.size();
        idx = 0;
        cyc = 0;
        while (idx < n2 && cyc < 400) begin
            check("r_o", 32'(r_o), 32'd1);
            check("busy", 32'(busy), 32'd1);
            check("dataOut", 32'(dataOut), 32'(exp_half(idx)));
            if (inject_wr && cyc == 0) begin
                wr_en     = 1'b1;
                wr_data   = 32'hFFFF_FFFF;
                ack       = 1'b0;
                model_err = 2'b11;
            end else begin
                ack = random_ack ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (ack) idx++;
            tick();
            wr_en = 1'b0;
            cyc++;
            if (inject_wr && cyc == 1) begin
                check("busy_wr_err", 32'(err), 32'(model_err));
                check("busy_wr_count", 32'(count), 32'(model_q.size()));
            end
        end
        ack = 1'b0;
        check("no_timeout", 32'(cyc < 400), 32'd1);
        if (!random_ack && !inject_wr) check("b2b_cycles", 32'(cyc), 32'(n2));
        check("done_pulse", 32'(done), 32'd1);
        check("done_r_o", 32'(r_o), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        tick();
        check("done_clear", 32'(done), 32'd0);
        check("idle_data", 32'(dataOut), 32'd0);
    endtask

    task automatic play(input bit random_ack, input bit inject_wr);
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(random_ack, inject_wr);
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0; ack = 1'b0;
        model_err = 2'b00;
        tick();
        tick();
        check("rst_r_o", 32'(r_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data", 32'(dataOut), 32'd0);
        reset = 1'b1;
        tick();

        // Reset in the middle of playback
        for (int i = 0; i < 3; i++) write_word($urandom);
        start = 1'b1; tick(); start = 1'b0;
        ack = 1'b1;
        tick(); tick(); tick();
        ack = 1'b0;
        check("mid_lo_w1", 32'(dataOut), 32'(model_q[1][15:0]));
        #2 reset = 1'b0;
        #1;
        check("async_r_o", 32'(r_o), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_count", 32'(count), 32'd0);
        check("async_err", 32'(err), 32'd0);
        reset = 1'b1;
        model_q.delete();
        model_err = 2'b00;
        tick();
        check("post_rst_r_o", 32'(r_o), 32'd0);
        check("post_rst_count", 32'(count), 32'd0);

        // Basic replay with ack tied high, twice
        write_word(32'h1234_5678);
        write_word(32'hDEAD_BEEF);
        play(1'b0, 1'b0);
        play(1'b0, 1'b0);

        // Backpressure
        do_clr();
        write_word(32'hA5A5_0F0F);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_r_o", 32'(r_o), 32'd1);
            check("bp_hold", 32'(dataOut), 32'h0000_A5A5);
            tick();
        end
        ack = 1'b1;
        tick();
        check("bp_lo", 32'(dataOut), 32'h0000_0F0F);
        tick();
        ack = 1'b0;
        check("bp_done", 32'(done), 32'd1);
        tick();

        // Empty start, then overflow
        do_clr();
        start = 1'b1; tick(); start = 1'b0;
        model_err = 2'b10;
        check("empty_err", 32'(err), 32'(model_err));
        check("empty_r_o", 32'(r_o), 32'd0);
        do_clr();
        check("clr_err", 32'(err), 32'd0);
        for (int i = 0; i < 11; i++) write_word($urandom);
        check("ovf_count", 32'(count), 32'd10);
        check("ovf_err", 32'(err), 32'd1);
        play(1'b1, 1'b0);

        // Write during playback
        do_clr();
        for (int i = 0; i < 4; i++) write_word($urandom);
        play(1'b1, 1'b1);
        check("after_busy_wr_count", 32'(count), 32'd4);

        // Write and start in the same cycle from empty
        do_clr();
        wr_data = $urandom;
        model_q.push_back(wr_data);
        wr_en = 1'b1; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        drain(1'b1, 1'b0);
        check("ws_count", 32'(count), 32'd1);

        // Clear has priority over start and write
        do_clr();
        write_word($urandom);
        write_word($urandom);
        clr = 1'b1; start = 1'b1; wr_en = 1'b1; wr_data = $urandom;
        tick();
        clr = 1'b0; start = 1'b0; wr_en = 1'b0;
        model_q.delete();
        model_err = 2'b00;
        check("clrp_count", 32'(count), 32'd0);
        check("clrp_err", 32'(err), 32'd0);
        check("clrp_r_o", 32'(r_o), 32'd0);
        tick();
        check("clrp_r_o2", 32'(r_o), 32'd0);

        // Random rounds
        for (int r = 0; r < 4; r++) begin
            do_clr();
            for (int i = 0; i < int'($urandom_range(1, DEPTH)); i++) write_word($urandom);
            play(1'b1, 1'b0);
            play(1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
